// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issues R-type requests to the combinational MIPS ALU, iterates
//               shift-by-1 ops for variable shifts, returns registered results.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int         W         = 32,
  parameter logic [5:0] NEG_FUNCT = 6'b111111
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   req_funct,
  input  logic [4:0]   req_shamt,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_overflow,
  output logic         rsp_illegal
);

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b0001;
  localparam logic [3:0] c_OP_SLL1 = 4'b0010;
  localparam logic [3:0] c_OP_SRL1 = 4'b0011;
  localparam logic [3:0] c_OP_SRA1 = 4'b0100;
  localparam logic [3:0] c_OP_NEG  = 4'b0101;
  localparam logic [3:0] c_OP_CMP  = 4'b0110;
  localparam logic [3:0] c_OP_AND  = 4'b0111;
  localparam logic [3:0] c_OP_OR   = 4'b1000;
  localparam logic [3:0] c_OP_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic [3:0]   r_op;
  logic         r_is_addsub;
  logic         r_is_slt;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_acc;
  logic [4:0]   r_cnt;
  logic [W-1:0] r_res;
  logic         r_ovf;
  logic         r_ill;

  logic [3:0]   w_op;
  logic         w_legal;
  logic         w_is_shift;
  logic         w_is_addsub;
  logic         w_is_slt;
  logic         w_accept;

  assign w_accept = req_valid && req_ready;

  always_comb begin
    w_op        = c_OP_IDLE;
    w_legal     = 1'b1;
    w_is_shift  = 1'b0;
    w_is_addsub = 1'b0;
    w_is_slt    = 1'b0;
    if (req_funct == NEG_FUNCT) begin
      w_op = c_OP_NEG;
    end else begin
      case (req_funct)
        6'b100000: begin w_op = c_OP_ADD;  w_is_addsub = 1'b1; end
        6'b100010: begin w_op = c_OP_SUB;  w_is_addsub = 1'b1; end
        6'b100100: w_op = c_OP_AND;
        6'b100101: w_op = c_OP_OR;
        6'b101010: begin w_op = c_OP_CMP;  w_is_slt = 1'b1; end
        6'b000000: begin w_op = c_OP_SLL1; w_is_shift = 1'b1; end
        6'b000010: begin w_op = c_OP_SRL1; w_is_shift = 1'b1; end
        6'b000011: begin w_op = c_OP_SRA1; w_is_shift = 1'b1; end
        default:   w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal)                                w_next = S_RESP;
          else if (w_is_shift && (req_shamt == 5'd0))  w_next = S_RESP;
          else if (w_is_shift)                         w_next = S_SHIFT;
          else                                         w_next = S_EXEC;
        end
      end
      S_EXEC:  w_next = S_RESP;
      S_SHIFT: if (r_cnt == 5'd1) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= c_OP_IDLE;
      r_is_addsub <= 1'b0;
      r_is_slt    <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= 5'd0;
      r_res       <= '0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= w_op;
            r_is_addsub <= w_is_addsub;
            r_is_slt    <= w_is_slt;
            r_a         <= req_a;
            r_b         <= req_b;
            r_acc       <= req_a;
            r_cnt       <= req_shamt;
            // A zero-length shift completes at accept with A unchanged.
            r_res       <= (w_legal && w_is_shift && (req_shamt == 5'd0)) ? req_a : '0;
            r_ovf       <= 1'b0;
            r_ill       <= ~w_legal;
          end
        end
        S_EXEC: begin
          r_res <= r_is_slt ? {{(W-1){1'b0}}, (alu_result == W'(2))} : alu_result;
          r_ovf <= r_is_addsub & alu_overflow;
        end
        S_SHIFT: begin
          r_acc <= alu_result;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_res <= alu_result;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_op = c_OP_IDLE;
    alu_a  = '0;
    alu_b  = '0;
    case (r_state)
      S_EXEC: begin
        alu_op = r_op;
        alu_a  = r_a;
        alu_b  = r_b;
      end
      S_SHIFT: begin
        alu_op = r_op;
        alu_a  = r_acc;
      end
      default: ;
    endcase
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = (r_state == S_RESP);
  assign rsp_result   = r_res;
  assign rsp_overflow = r_ovf;
  assign rsp_illegal  = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed and random checks of alu_issue_ctrl against an ALU
//               model and a funct-level reference of results and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [4:0]  req_shamt;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(32), .NEG_FUNCT(6'b111111)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_shamt(req_shamt),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_illegal(rsp_illegal)
  );

  // Combinational stand-in for the datapath ALU.
  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    case (alu_op)
      4'h0: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'h1: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'h2: alu_result = alu_a << 1;
      4'h3: alu_result = alu_a >> 1;
      4'h4: alu_result = $signed(alu_a) >>> 1;
      4'h5: alu_result = -alu_a;
      4'h6: alu_result = ($signed(alu_a) > $signed(alu_b)) ? 32'd1 :
                         ($signed(alu_a) < $signed(alu_b)) ? 32'd2 : 32'd0;
      4'h7: alu_result = alu_a & alu_b;
      4'h8: alu_result = alu_a | alu_b;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what the request means, independent of how it is sequenced.
  task automatic ref_model(input logic [5:0] f, input logic [4:0] sh,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic ov,
                           output logic ill, output int lat, output logic [3:0] op);
    logic [31:0] sa;
    res = 32'd0; ov = 1'b0; ill = 1'b0; lat = 2; op = 4'hF;
    case (f)
      6'b100000: begin res = a + b; op = 4'h0;
                       ov = (a[31] == b[31]) && (res[31] != a[31]); end
      6'b100010: begin res = a - b; op = 4'h1;
                       ov = (a[31] != b[31]) && (res[31] != a[31]); end
      6'b100100: begin res = a & b; op = 4'h7; end
      6'b100101: begin res = a | b; op = 4'h8; end
      6'b101010: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; op = 4'h6; end
      6'b111111: begin res = 32'd0 - a; op = 4'h5; end
      6'b000000: begin res = a << sh; op = 4'h2; lat = 1 + int'(sh); end
      6'b000010: begin res = a >> sh; op = 4'h3; lat = 1 + int'(sh); end
      6'b000011: begin sa = $signed(a) >>> sh; res = sa; op = 4'h4; lat = 1 + int'(sh); end
      default:   begin ill = 1'b1; lat = 1; end
    endcase
  endtask

  // Entered and left one time unit after a rising edge, with the DUT idle.
  task automatic run_op(input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] eres; logic eov; logic eill; int elat; logic [3:0] eop;
    logic [31:0] held;
    int n;
    ref_model(f, sh, a, b, eres, eov, eill, elat, eop);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_funct = f; req_shamt = sh; req_a = a; req_b = b;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n <= 40) begin
      chk("alu_op_busy", {28'd0, alu_op}, {28'd0, eop});
      if (elat == 2) begin
        chk("alu_a_exec", alu_a, a);
        chk("alu_b_exec", alu_b, b);
      end
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, elat);
    chk("alu_op_resp", {28'd0, alu_op}, 32'hF);
    chk("rsp_result", rsp_result, eres);
    chk("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, eov});
    chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, eill});
    held = rsp_result;
    // A competing request during backpressure must not be taken.
    req_valid = 1'b1; req_funct = 6'b100000; req_a = ~a; req_b = ~b;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_result", rsp_result, held);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [5:0] fl [10];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
           6'b111111, 6'b000000, 6'b000010, 6'b000011, 6'b011000};
    reset = 1'b1; req_valid = 1'b0; req_funct = 6'd0; req_shamt = 5'd0;
    req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_ovf", {31'd0, rsp_overflow}, 32'd0);
    chk("rst_rsp_ill", {31'd0, rsp_illegal}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'hF);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);

    run_op(6'b100000, 5'd0,  32'h7FFFFFFF, 32'h00000001, 0);
    run_op(6'b000000, 5'd4,  32'h00000001, 32'd0, 0);
    run_op(6'b000000, 5'd0,  32'h00000001, 32'd0, 0);
    run_op(6'b000011, 5'd31, 32'h80000000, 32'd0, 0);
    run_op(6'b000010, 5'd31, 32'h80000000, 32'd0, 0);
    run_op(6'b101010, 5'd0,  32'hFFFFFFFF, 32'h00000001, 0);
    run_op(6'b101010, 5'd0,  32'h00000001, 32'hFFFFFFFF, 0);
    run_op(6'b101010, 5'd0,  32'h00000005, 32'h00000005, 0);
    run_op(6'b100101, 5'd0,  32'h000000F0, 32'h0000000F, 3);
    run_op(6'b100010, 5'd0,  32'h80000000, 32'h00000001, 1);
    run_op(6'b111111, 5'd0,  32'h00000007, 32'd0, 0);
    run_op(6'b111110, 5'd9,  32'h12345678, 32'h9ABCDEF0, 0);

    // Reset in the middle of a long shift discards it entirely.
    req_valid = 1'b1; req_funct = 6'b000000; req_shamt = 5'd20;
    req_a = 32'h1; req_b = 32'd0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_alu_op", {28'd0, alu_op}, 32'hF);
    for (int k = 0; k < 25; k++) begin
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      run_op(fl[$urandom_range(0, 9)], 5'($urandom_range(0, 31)),
             $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Front-end that drives the MIPS datapath ALU's A/B/op inputs from R-type requests and returns registered results over valid/ready handshakes.
- Decodes the funct field to the ALU's 4-bit op code.
- Builds variable-amount shifts by issuing the ALU's shift-by-1 ops once per cycle, shamt times.
- Sits between the decode/issue stage and the combinational ALU.

Parameters:
- W, 32, datapath width (the ALU is fixed at 32; other values are unsupported).
- NEG_FUNCT, 6'b111111, team-reserved funct that selects ALU negate.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  ready to accept a request
- req_funct  in  6  MIPS funct field
- req_shamt  in  5  shift amount
- req_a  in  32  operand A (rs; rt for shifts)
- req_b  in  32  operand B (rt)
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  4  ALU op code
- alu_result  in  32  ALU result (combinational)
- alu_overflow  in  1  ALU overflow flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  32  final result
- rsp_overflow  out  1  overflow; valid for add/sub only, 0 otherwise
- rsp_illegal  out  1  funct not supported

Behaviour:
- ALU op codes: 0000 add, 0001 sub, 0010 sll1, 0011 srl1, 0100 sra1, 0101 neg, 0110 compare (1 if A>B, 2 if A<B, 0 if equal; signed), 0111 and, 1000 or. 1111 = idle (ALU outputs 0).
- Funct decode:
  - 100000 add and 100010 sub use the single-cycle path.
  - 100100 and and 100101 or use the single-cycle path.
  - 101010 slt issues compare; rsp_result = (alu_result==2) ? 1 : 0.
  - NEG_FUNCT issues neg on A.
  - 000000 sll, 000010 srl, 000011 sra use the iterative path.
  - Any other funct is illegal.
- FSM states: IDLE, EXEC, SHIFT, RESP.
  - IDLE: req_ready=1. A handshake (req_valid&&req_ready) at cycle T latches the request. Next state: illegal -> RESP; shift with shamt==0 -> RESP; shift with shamt>0 -> SHIFT; otherwise -> EXEC.
  - EXEC (one cycle): alu_a=A, alu_b=B, alu_op=decoded. Capture alu_result, plus alu_overflow for add/sub only. Go to RESP.
  - SHIFT: accumulator initialised to req_a and a 5-bit counter to shamt at accept. Each cycle: alu_a=acc, alu_op=shift op, acc<=alu_result, cnt<=cnt-1. When cnt==1 the captured value is final; go to RESP.
  - RESP: rsp_valid=1. rsp_result, rsp_overflow and rsp_illegal are held stable until rsp_ready. A handshake returns to IDLE, where the next request can be accepted.
- Latency from accept at T to rsp_valid:
  - T+2 for single-cycle ops.
  - T+1+shamt for shifts with shamt>=1.
  - T+1 for shamt==0 (result = A unchanged) and for illegal funct.
- Illegal response: rsp_result=0, rsp_overflow=0, rsp_illegal=1. No ALU op is issued.
- Outside EXEC/SHIFT: alu_op=1111, alu_a=0, alu_b=0. req_ready=0 in every state except IDLE.
- No request pipelining: at most one operation in flight. Requests are not accepted while in RESP, even if rsp_ready is high.
- Reset values: state IDLE, req_ready=1 (combinational from state), rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_illegal=0, alu_op=1111, alu_a=0, alu_b=0, acc=0, cnt=0.
- Reset mid-operation (EXEC/SHIFT/RESP): the in-flight operation and any pending response are discarded. No rsp_valid pulse appears. The first cycle after reset is IDLE.
- Shift of 31 via sra1 on negative A saturates to 0xFFFFFFFF. Shift of 31 via srl1/sll1 leaves a single bit or zero, per standard semantics.

Test Plan:
- add, A=0x7FFFFFFF, B=0x00000001, rsp_ready=1 -> rsp_valid at T+2 with result 0x80000000 and rsp_overflow=1. alu_op=0000 for exactly one cycle.
- sll, A=0x00000001, shamt=4 -> alu_op=0010 for 4 consecutive cycles, then rsp_result=0x00000010 at T+5 with overflow=0. shamt=0 -> result 0x00000001 at T+1.
- sra, A=0x80000000, shamt=31 -> rsp_result=0xFFFFFFFF at T+32. Same stimulus with srl -> 0x00000001.
- slt, A=0xFFFFFFFF, B=0x00000001 -> result 1. Swapped operands -> 0. Equal operands -> 0.
- Backpressure: or, A=0xF0, B=0x0F, rsp_ready low for 3 cycles -> rsp_valid=1 with 0x000000FF held stable and req_ready=0 throughout. A second request is accepted only after the RESP handshake.
- funct=6'b111110 -> rsp_illegal=1, result 0 at T+1, alu_op stays 1111. Reset asserted during a shamt=20 shift -> no response, req_ready=1 the cycle after reset.
